// File: rtl/dump_state_if.sv
// dump_state_if: write-back bus between dump_state and the channel state
// buffer / accumulator RAM.
//   state_wr, state_addr, state_d4wr : state buffer write request, address, data
//   state_wr_ready                   : buffer accepts the write this cycle
//   acc_rd, acc_addr                 : accumulator RAM read strobe and word index
//   acc_data                         : accumulator read data, valid one cycle after acc_rd
// Modports: master = dump_state side, slave = buffer/RAM side.
interface dump_state_if #(
  parameter int ACC_AWIDTH = 4
);
  logic                  state_wr;
  logic [4:0]            state_addr;
  logic [31:0]           state_d4wr;
  logic                  state_wr_ready;
  logic                  acc_rd;
  logic [ACC_AWIDTH-1:0] acc_addr;
  logic [31:0]           acc_data;

  modport master (
    output state_wr, state_addr, state_d4wr, acc_rd, acc_addr,
    input  state_wr_ready, acc_data
  );

  modport slave (
    input  state_wr, state_addr, state_d4wr, acc_rd, acc_addr,
    output state_wr_ready, acc_data
  );
endinterface

// File: rtl/dump_state.sv
// dump_state: snapshots a physical channel's variable state after a
// correlation round and writes it back to the channel state buffer, then
// copies the coherent accumulator words from the accumulator RAM to state
// addresses 16..16+ACC_WORDS-1.
// Ports:
//   clk, rst_b       : clock, synchronous active-high reset
//   dump_enable      : start pulse, ignored while busy
//   prn_state..prn2_state : channel variables for state addresses 6..15
//   bus (master)     : state buffer write port and accumulator read port
//   busy             : sequence in progress
//   dump_done        : one-cycle completion pulse
// Build option: DUMP_2ND_PRN_EN -- when defined, prn2_state is snapshotted
// and written at address 15; otherwise the variable phase ends at address 14.
module dump_state #(
  parameter int ACC_WORDS  = 8,
  parameter int ACC_AWIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               dump_enable,
  input  logic [31:0]        prn_state,
  input  logic [31:0]        prn_count,
  input  logic [31:0]        carrier_phase,
  input  logic [31:0]        carrier_count,
  input  logic [31:0]        code_phase,
  input  logic [31:0]        prn_code,
  input  logic [31:0]        corr_state,
  input  logic [31:0]        decode_data,
  input  logic [31:0]        prn_config2,
  input  logic [31:0]        prn2_state,
  dump_state_if.master       bus,
  output logic               busy,
  output logic               dump_done
);

`ifdef DUMP_2ND_PRN_EN
  localparam int unsigned NUM_VAR = 10;
`else
  localparam int unsigned NUM_VAR = 9;
  logic w_unused_prn2;
  assign w_unused_prn2 = ^prn2_state;
`endif
  localparam logic [4:0]            VAR_LAST = 5'(5 + NUM_VAR);
  localparam logic [ACC_AWIDTH-1:0] ACC_LAST = ACC_AWIDTH'(ACC_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VAR,
    S_ACC_RD,
    S_ACC_WR,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_snap [NUM_VAR];
  logic [4:0]            r_addr;
  logic [ACC_AWIDTH-1:0] r_acc;
  logic [31:0]           r_hold;
  logic                  r_hold_vld;
  logic [3:0]            w_var_idx;
  logic [31:0]           w_acc_word;

  assign w_var_idx = 4'(r_addr - 5'd6);
  // acc_data is only valid in the first ACC_WR cycle; it is forwarded then
  // and the captured copy is used for any further stall cycles.
  assign w_acc_word = r_hold_vld ? r_hold : bus.acc_data;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int unsigned i = 0; i < NUM_VAR; i++) r_snap[i] <= '0;
    end else if (r_state == S_IDLE && dump_enable) begin
      r_snap[0] <= prn_state;
      r_snap[1] <= prn_count;
      r_snap[2] <= carrier_phase;
      r_snap[3] <= carrier_count;
      r_snap[4] <= code_phase;
      r_snap[5] <= prn_code;
      r_snap[6] <= corr_state;
      r_snap[7] <= decode_data;
      r_snap[8] <= prn_config2;
`ifdef DUMP_2ND_PRN_EN
      r_snap[9] <= prn2_state;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_acc      <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (dump_enable) begin
            r_addr <= 5'd6;
            r_acc  <= '0;
          end
        end
        S_VAR: begin
          if (bus.state_wr_ready && r_addr != VAR_LAST) r_addr <= 5'(r_addr + 5'd1);
        end
        S_ACC_RD: r_hold_vld <= 1'b0;
        S_ACC_WR: begin
          if (!r_hold_vld) begin
            r_hold     <= bus.acc_data;
            r_hold_vld <= 1'b1;
          end
          if (bus.state_wr_ready && r_acc != ACC_LAST) r_acc <= ACC_AWIDTH'(r_acc + 1'b1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    busy           = 1'b0;
    dump_done      = 1'b0;
    bus.state_wr   = 1'b0;
    bus.state_addr = '0;
    bus.state_d4wr = '0;
    bus.acc_rd     = 1'b0;
    bus.acc_addr   = '0;
    case (r_state)
      S_IDLE: begin
        if (dump_enable) w_next = S_VAR;
      end
      S_VAR: begin
        busy           = 1'b1;
        bus.state_wr   = 1'b1;
        bus.state_addr = r_addr;
        bus.state_d4wr = r_snap[w_var_idx];
        if (bus.state_wr_ready && r_addr == VAR_LAST) w_next = S_ACC_RD;
      end
      S_ACC_RD: begin
        busy         = 1'b1;
        bus.acc_rd   = 1'b1;
        bus.acc_addr = r_acc;
        w_next       = S_ACC_WR;
      end
      S_ACC_WR: begin
        busy           = 1'b1;
        bus.state_wr   = 1'b1;
        bus.state_addr = 5'(5'd16 + 5'(r_acc));
        bus.state_d4wr = w_acc_word;
        bus.acc_addr   = r_acc;
        if (bus.state_wr_ready) w_next = (r_acc == ACC_LAST) ? S_DONE : S_ACC_RD;
      end
      S_DONE: begin
        busy      = 1'b1;
        dump_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dump_state.sv
module tb_dump_state;
  localparam int AW  = 8;
  localparam int AAW = 4;
`ifdef DUMP_2ND_PRN_EN
  localparam int NV = 10;
`else
  localparam int NV = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, de, de1, busy, done, busy1, done1;
  logic [31:0] ch [10];

  dump_state_if #(.ACC_AWIDTH(AAW)) if0 ();
  dump_state_if #(.ACC_AWIDTH(AAW)) if1 ();

  dump_state #(.ACC_WORDS(AW), .ACC_AWIDTH(AAW)) u0 (
    .clk(clk), .rst_b(rst_b), .dump_enable(de),
    .prn_state(ch[0]), .prn_count(ch[1]), .carrier_phase(ch[2]), .carrier_count(ch[3]),
    .code_phase(ch[4]), .prn_code(ch[5]), .corr_state(ch[6]), .decode_data(ch[7]),
    .prn_config2(ch[8]), .prn2_state(ch[9]),
    .bus(if0), .busy(busy), .dump_done(done)
  );

  dump_state #(.ACC_WORDS(1), .ACC_AWIDTH(AAW)) u1 (
    .clk(clk), .rst_b(rst_b), .dump_enable(de1),
    .prn_state(ch[0]), .prn_count(ch[1]), .carrier_phase(ch[2]), .carrier_count(ch[3]),
    .code_phase(ch[4]), .prn_code(ch[5]), .corr_state(ch[6]), .decode_data(ch[7]),
    .prn_config2(ch[8]), .prn2_state(ch[9]),
    .bus(if1), .busy(busy1), .dump_done(done1)
  );

  // Accumulator RAM models: data valid one cycle after acc_rd, noise otherwise.
  always @(posedge clk) begin
    if0.acc_data <= if0.acc_rd ? 32'hA000_0000 + 32'(if0.acc_addr) : $urandom;
    if1.acc_data <= if1.acc_rd ? 32'hA000_0000 + 32'(if1.acc_addr) : $urandom;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int edge0 = 0;
  int edge1 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp1_q[$];
  int done_cnt = 0, done_rel = 0, done1_cnt = 0, done1_rel = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor for the ACC_WORDS=8 instance.
  logic        stall_p = 1'b0;
  logic [4:0]  stall_a;
  logic [31:0] stall_d;
  always @(negedge clk) begin
    wr_t w;
    if (stall_p) begin
      chk("stall_wr", 64'(if0.state_wr), 64'd1);
      chk("stall_addr", 64'(if0.state_addr), 64'(stall_a));
      chk("stall_data", 64'(if0.state_d4wr), 64'(stall_d));
    end
    stall_p = (if0.state_wr === 1'b1) && (if0.state_wr_ready === 1'b0);
    stall_a = if0.state_addr;
    stall_d = if0.state_d4wr;
    if (if0.state_wr === 1'b1 && if0.state_wr_ready === 1'b1) begin
      chk("addr_bound", 64'(if0.state_addr <= 5'(16 + AW - 1)), 64'd1);
      if (exp_q.size() == 0) chk("extra_write", 64'(exp_q.size()), 64'd1);
      else begin
        w = exp_q.pop_front();
        chk("wr_addr", 64'(if0.state_addr), 64'(w.a));
        chk("wr_data", 64'(if0.state_d4wr), 64'(w.d));
      end
    end
    if (if0.acc_rd === 1'b1) chk("acc_bound", 64'(if0.acc_addr <= AAW'(AW - 1)), 64'd1);
    if (done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - edge0;
    end
  end

  // Scoreboard monitor for the ACC_WORDS=1 instance.
  always @(negedge clk) begin
    wr_t w;
    if (if1.state_wr === 1'b1 && if1.state_wr_ready === 1'b1) begin
      if (exp1_q.size() == 0) chk("extra_write1", 64'(exp1_q.size()), 64'd1);
      else begin
        w = exp1_q.pop_front();
        chk("wr1_addr", 64'(if1.state_addr), 64'(w.a));
        chk("wr1_data", 64'(if1.state_d4wr), 64'(w.d));
      end
    end
    if (if1.acc_rd === 1'b1) chk("acc1_addr", 64'(if1.acc_addr), 64'd0);
    if (done1 === 1'b1) begin
      done1_cnt++;
      done1_rel = cyc - edge1;
    end
  end

  function automatic logic [31:0] chval(input int a, input logic [31:0] salt);
    logic [7:0] b;
    b = 8'((a / 10) * 16 + (a % 10));
    return {4{b}} ^ salt;
  endfunction

  // mode 0 plain, 1 inputs churn, 2 ready stalls, 3 re-pulse, 4 mid-run reset.
  // Entered and left at posedge+#1.
  task automatic run(input int mode, input logic [31:0] salt);
    int done_exp, rel, s9, s18;
    logic [31:0] v;
    done_exp = NV + 2 * AW + 1 + ((mode == 2) ? 5 : 0);
    for (int a = 6; a < 16; a++) begin
      v = chval(a, salt);
      ch[a - 6] = v;
      if (a < 6 + NV) exp_q.push_back({5'(a), v});
    end
    for (int i = 0; i < AW; i++) exp_q.push_back({5'(16 + i), 32'hA000_0000 + 32'(i)});
    done_cnt = 0;
    s9 = 0;
    s18 = 0;
    if0.state_wr_ready = 1'b1;
    de = 1'b1;
    @(posedge clk); #1;
    edge0 = cyc - 1;
    de = 1'b0;
    rel = 1;
    repeat (done_exp + 4) begin
      if (mode == 1 || (mode == 3 && rel == 5))
        for (int j = 0; j < 10; j++) ch[j] = $urandom;
      if (mode == 2) begin
        if0.state_wr_ready = 1'b1;
        if (if0.state_wr === 1'b1 && if0.state_addr == 5'd9 && s9 < 3) begin
          if0.state_wr_ready = 1'b0;
          s9++;
        end else if (if0.state_wr === 1'b1 && if0.state_addr == 5'd18 && s18 < 2) begin
          if0.state_wr_ready = 1'b0;
          s18++;
        end
      end
      if (mode == 3) de = (rel == 5) || (done === 1'b1);
      if (mode == 4 && rel == 14) rst_b = 1'b1;
      if (mode == 4 && rel == 15) begin
        chk("midrst_outs", 64'({if0.state_wr, if0.state_addr, if0.state_d4wr, if0.acc_rd,
                               if0.acc_addr, busy, done}), 64'd0);
        rst_b = 1'b0;
      end
      @(negedge clk);
      chk("busy", 64'(busy),
          64'((rel >= 1) && (rel <= done_exp) && !(mode == 4 && rel >= 15)));
      @(posedge clk); #1;
      rel++;
    end
    de = 1'b0;
    if0.state_wr_ready = 1'b1;
    if (mode == 4) begin
      chk("midrst_no_done", 64'(done_cnt), 64'd0);
      exp_q.delete();
    end else begin
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("done_cycle", 64'(done_rel), 64'(done_exp));
      chk("all_written", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] v;
    rst_b = 1'b1;
    de = 1'b0;
    de1 = 1'b0;
    if0.state_wr_ready = 1'b1;
    if1.state_wr_ready = 1'b1;
    for (int j = 0; j < 10; j++) ch[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs0", 64'({if0.state_wr, if0.state_addr, if0.state_d4wr, if0.acc_rd,
                          if0.acc_addr, busy, done}), 64'd0);
    chk("rst_outs1", 64'({if1.state_wr, if1.state_addr, if1.state_d4wr, if1.acc_rd,
                          if1.acc_addr, busy1, done1}), 64'd0);
    rst_b = 1'b0;
    @(posedge clk); #1;

    run(0, 32'h0);
    run(1, 32'h1357_9BDF);
    run(2, 32'h2468_ACE0);
    run(3, 32'h0F0F_F0F0);
    run(4, 32'h5A5A_A5A5);
    run(0, 32'hC3C3_3C3C);

    // ACC_WORDS=1 instance
    for (int a = 6; a < 16; a++) begin
      v = chval(a, 32'h7E7E_0101);
      ch[a - 6] = v;
      if (a < 6 + NV) exp1_q.push_back({5'(a), v});
    end
    exp1_q.push_back({5'd16, 32'hA000_0000});
    de1 = 1'b1;
    @(posedge clk); #1;
    edge1 = cyc - 1;
    de1 = 1'b0;
    for (int j = 0; j < 10; j++) ch[j] = $urandom;
    repeat (NV + 6) @(posedge clk);
    #1;
    chk("done1_count", 64'(done1_cnt), 64'd1);
    chk("done1_cycle", 64'(done1_rel), 64'(NV + 3));
    chk("all_written1", 64'(exp1_q.size()), 64'd0);
    chk("busy1_idle", 64'(busy1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
